// File: rtl/pipeline_hazard_ctrl.sv
// Stage-enable / flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory wait freezes with timeout. Optional macro: PERF_CNT_EN (perf counters).
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       AddrA_ID,
    input  logic [4:0]       AddrB_ID,
    input  logic             useA_ID,
    input  logic             useB_ID,
    input  logic [4:0]       Rd_EX,
    input  logic             MemRead_EX,
    input  logic             BrTaken_EX,
    input  logic             MemAcc_MEM,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state_dbg_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic mem_stall;
    logic load_use;

    assign mem_stall = MemAcc_MEM & ~dmem_ready;
    // XZR is never a real producer, so a load into X31 cannot create a hazard.
    assign load_use  = MemRead_EX & (Rd_EX != 5'd31) &
                       ((useA_ID & (AddrA_ID == Rd_EX)) | (useB_ID & (AddrB_ID == Rd_EX)));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;

        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
            state_d      = ST_RUN;
            wait_cnt_d   = '0;
            mem_err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if ((state_q == ST_MEM_WAIT) && !dmem_ready) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d   = ST_HALT;
                            mem_err_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end else begin
                        // A released wait falls through to the normal RUN priority this cycle.
                        state_d    = ST_RUN;
                        wait_cnt_d = '0;
                        if (mem_stall) begin
                            pc_en        = 1'b0;
                            ifid_en      = 1'b0;
                            idex_en      = 1'b0;
                            exmem_en     = 1'b0;
                            memwb_bubble = 1'b1;
                            state_d      = ST_MEM_WAIT;
                            wait_cnt_d   = WAIT_W'(1);
                        end else if (BrTaken_EX) begin
                            ifid_flush  = 1'b1;
                            idex_bubble = 1'b1;
                        end else if (load_use) begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_bubble = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                end
                default: begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err     = mem_err_q;
    assign state_dbg_o = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             flush_evt;

    // A flush is the only decision that raises ifid_flush while the PC still advances.
    assign flush_evt = ifid_flush & pc_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

    localparam int T  = 4;
    localparam int CW = 16;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [4:0]    AddrA_ID, AddrB_ID, Rd_EX;
    logic          useA_ID, useB_ID, MemRead_EX, BrTaken_EX, MemAcc_MEM, dmem_ready;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, mem_err;
    logic [CW-1:0] stall_count, flush_count;
    logic [1:0]    state_dbg;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .AddrA_ID(AddrA_ID), .AddrB_ID(AddrB_ID), .useA_ID(useA_ID), .useB_ID(useB_ID),
        .Rd_EX(Rd_EX), .MemRead_EX(MemRead_EX), .BrTaken_EX(BrTaken_EX),
        .MemAcc_MEM(MemAcc_MEM), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count),
        .state_dbg_o(state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 = running, 1 = waiting on memory, 2 = halted.
    int m_mode  = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    localparam logic [6:0] P_RESET  = 7'b0010101;
    localparam logic [6:0] P_FROZEN = 7'b0000001;
    localparam logic [6:0] P_FLUSH  = 7'b1111110;
    localparam logic [6:0] P_LU     = 7'b0001110;
    localparam logic [6:0] P_NORMAL = 7'b1101010;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}
    function automatic logic [6:0] model_ctl();
        bit hazard;
        hazard = MemRead_EX && (Rd_EX != 5'd31) &&
                 ((useA_ID && (AddrA_ID == Rd_EX)) || (useB_ID && (AddrB_ID == Rd_EX)));
        if (reset)                                return P_RESET;
        if (m_mode == 2)                          return P_FROZEN;
        if (m_mode == 1 && !dmem_ready)           return P_FROZEN;
        if (MemAcc_MEM && !dmem_ready)            return P_FROZEN;
        if (BrTaken_EX)                           return P_FLUSH;
        if (hazard)                               return P_LU;
        return P_NORMAL;
    endfunction

    function automatic logic [39:0] model_all();
        logic [15:0] es, ef;
        es = PERF ? 16'(m_stall) : 16'd0;
        ef = PERF ? 16'(m_flush) : 16'd0;
        return {model_ctl(), m_err, es, ef};
    endfunction

    function automatic logic [39:0] dut_all();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble,
                mem_err, stall_count, flush_count};
    endfunction

    task automatic model_step();
        logic [6:0] c;
        c = model_ctl();
        if (reset) begin
            m_mode = 0; m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
            return;
        end
        if (c[6] == 1'b0 && m_stall < 65535) m_stall++;
        if (c == P_FLUSH && m_flush < 65535) m_flush++;
        case (m_mode)
            0: if (MemAcc_MEM && !dmem_ready) begin m_mode = 1; m_wait = 1; end
            1: begin
                if (dmem_ready) begin
                    m_mode = 0; m_wait = 0;
                    if (MemAcc_MEM && !dmem_ready) m_mode = 1;
                end else if (m_wait == T - 1) begin
                    m_mode = 2; m_err = 1'b1;
                end else begin
                    m_wait++;
                end
            end
            default: m_mode = 2;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input bit ma, input bit rdy, input bit br, input bit mr,
                          input logic [4:0] rd, input logic [4:0] aa, input bit ua,
                          input logic [4:0] ab, input bit ub);
        MemAcc_MEM = ma; dmem_ready = rdy; BrTaken_EX = br; MemRead_EX = mr;
        Rd_EX = rd; AddrA_ID = aa; useA_ID = ua; AddrB_ID = ab; useB_ID = ub;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 5'd2, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] e, o;
        reset = 1'b1;
        idle();
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 1'b0);
            @(negedge clk);
            e = model_all(); o = dut_all(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_cyc%0d: got %h want %h", i, o, e); end
            tick();
        end
        reset = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (!(mem_err === 1'b0 && stall_count === 16'd0 && flush_count === 16'd0)) begin
            errors++;
            $display("FAIL reset_regs: mem_err=%b stall=%0d flush=%0d want 0 0 0", mem_err, stall_count, flush_count);
        end
        checks++;
        if ({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble} !== P_NORMAL) begin
            errors++;
            $display("FAIL reset_first_run: got %b want %b",
                     {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}, P_NORMAL);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd9, 1'b0);
        @(negedge clk);
        checks++;
        if (!(pc_en === 1'b0 && ifid_en === 1'b0 && idex_bubble === 1'b1 && exmem_en === 1'b1)) begin
            errors++;
            $display("FAIL load_use_stall: pc=%b ifid=%b bub=%b exmem=%b want 0 0 1 1", pc_en, ifid_en, idex_bubble, exmem_en);
        end
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd9, 1'b0);
        @(negedge clk);
        checks++;
        if (!(pc_en === 1'b1 && idex_bubble === 1'b0)) begin
            errors++;
            $display("FAIL load_use_once: pc=%b bub=%b want 1 0", pc_en, idex_bubble);
        end
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1);
        @(negedge clk);
        checks++;
        if (!(pc_en === 1'b1 && idex_bubble === 1'b0)) begin
            errors++;
            $display("FAIL load_use_xzr: pc=%b bub=%b want 1 0", pc_en, idex_bubble);
        end
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b0) begin errors++; $display("FAIL load_use_portb: pc=%b want 0", pc_en); end
        tick();
    endtask

    task automatic test_branch_loaduse();
        do_reset();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd9, 1'b0);
        @(negedge clk);
        checks++;
        if (!(ifid_flush === 1'b1 && idex_bubble === 1'b1 && pc_en === 1'b1 && ifid_en === 1'b1)) begin
            errors++;
            $display("FAIL branch_lu: flush=%b bub=%b pc=%b ifid=%b want 1 1 1 1", ifid_flush, idex_bubble, pc_en, ifid_en);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (flush_count !== (PERF ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL branch_count: got %0d want %0d", flush_count, PERF ? 1 : 0);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, (i == 3), 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 5'd2, 1'b0);
            @(negedge clk);
            checks++;
            if (pc_en !== (i == 3) || exmem_en !== (i == 3) || memwb_bubble !== (i != 3)) begin
                errors++;
                $display("FAIL mem_wait_cyc%0d: pc=%b exmem=%b wb_bub=%b", i, pc_en, exmem_en, memwb_bubble);
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (stall_count !== (PERF ? 16'd3 : 16'd0)) begin
            errors++;
            $display("FAIL mem_wait_count: got %0d want %0d", stall_count, PERF ? 3 : 0);
        end
        tick();
    endtask

    task automatic test_wait_vs_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, (i == 2), 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 5'd2, 1'b0);
            @(negedge clk);
            checks++;
            if (ifid_flush !== (i == 2) || pc_en !== (i == 2)) begin
                errors++;
                $display("FAIL wait_branch_cyc%0d: flush=%b pc=%b want %0d %0d", i, ifid_flush, pc_en, i == 2, i == 2);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            // Memory recovers late; the halt must already be sticky.
            set_in(i < 6, i >= 6, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 5'd2, 1'b0);
            @(negedge clk);
            checks++;
            if (mem_err !== (i >= T) || pc_en !== 1'b0 || exmem_en !== 1'b0) begin
                errors++;
                $display("FAIL timeout_cyc%0d: err=%b pc=%b exmem=%b want %0d 0 0", i, mem_err, pc_en, exmem_en, i >= T);
            end
            tick();
        end
        do_reset();
        idle();
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b0 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: err=%b pc=%b want 0 1", mem_err, pc_en);
        end
        tick();
    endtask

    task automatic test_random();
        logic [39:0] e, o;
        logic [4:0] rd, aa, ab;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rd = ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
            aa = ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
            ab = 5'($urandom_range(0, 3));
            reset = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 1) == 0, rd, aa, 1'($urandom), ab, 1'($urandom));
            @(negedge clk);
            e = model_all(); o = dut_all(); checks++;
            if (o !== e) begin errors++; $display("FAIL random_cyc%0d: got %h want %h", i, o, e); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_branch_loaduse();
        test_mem_wait();
        test_wait_vs_branch();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
